bht_port_arbiter: RTL

BHT_PORT_ARBITER -- requirements
Module: bht_port_arbiter

---
 rtl/bht_port_arbiter_if.sv | 47 ++++
 rtl/bht_port_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bht_port_arbiter_if.sv
// Port bundle for the BHT port arbiter: flush control, the fetch lookup
// port, the execute update port, the single-port BHT RAM and statistics.
//
// Handshake: a lookup or update transfers on a rising clk edge where both
// *_valid and *_ready are high. A requester holds valid and its payload
// stable until that edge. Ready is combinational and may depend on valid
// (lkp_ready drops while upd_valid is high), but never the other way round.
interface bht_port_arbiter_if #(
   parameter int TABLE_ADR_WIDTH = 6,
   parameter int CTR_WIDTH       = 2
);
   logic                       flush_req;
   logic                       flush_busy;
   logic                       lkp_valid;
   logic [31:0]                lkp_pc;
   logic                       lkp_ready;
   logic                       pred_valid;
   logic                       pred_taken;
   logic                       upd_valid;
   logic [31:0]                upd_pc;
   logic                       upd_taken;
   logic                       upd_pred;
   logic                       upd_ready;
   logic                       mem_en;
   logic                       mem_we;
   logic [TABLE_ADR_WIDTH-1:0] mem_addr;
   logic [CTR_WIDTH-1:0]       mem_wdata;
   logic [CTR_WIDTH-1:0]       mem_rdata;
   logic [31:0]                stat_total;
   logic [31:0]                stat_correct;

   // Environment side: requesters plus the RAM that returns read data.
   modport master (
      output flush_req, lkp_valid, lkp_pc, upd_valid, upd_pc, upd_taken,
             upd_pred, mem_rdata,
      input  flush_busy, lkp_ready, pred_valid, pred_taken, upd_ready,
             mem_en, mem_we, mem_addr, mem_wdata, stat_total, stat_correct
   );

   // Arbiter side.
   modport slave (
      input  flush_req, lkp_valid, lkp_pc, upd_valid, upd_pc, upd_taken,
             upd_pred, mem_rdata,
      output flush_busy, lkp_ready, pred_valid, pred_taken, upd_ready,
             mem_en, mem_we, mem_addr, mem_wdata, stat_total, stat_correct
   );
endinterface

// File: rtl/bht_port_arbiter.sv
// BHT port arbiter: shares one single-port RAM of saturating counters
// between a flush sweep, resolved-branch updates (read-modify-write) and
// prediction lookups. Priority in IDLE: flush > update > lookup.
module bht_port_arbiter #(
   parameter int TABLE_ADR_WIDTH = 6,
   parameter int CTR_WIDTH       = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   bht_port_arbiter_if.slave bus,
   output logic [1:0]        dbg_state_o
);

   localparam logic [1:0] ST_FLUSH  = 2'd0;
   localparam logic [1:0] ST_IDLE   = 2'd1;
   localparam logic [1:0] ST_UPD_RD = 2'd2;
   localparam logic [1:0] ST_UPD_WR = 2'd3;

   localparam logic [TABLE_ADR_WIDTH-1:0] LAST_IDX = '1;
   localparam logic [CTR_WIDTH-1:0]       CTR_MAX  = '1;
   localparam logic [CTR_WIDTH-1:0]       CTR_MIN  = '0;

   logic [1:0]                 state_q,        state_d;
   logic [TABLE_ADR_WIDTH-1:0] flush_idx_q,    flush_idx_d;
   logic [TABLE_ADR_WIDTH-1:0] upd_idx_q,      upd_idx_d;
   logic                       upd_taken_q,    upd_taken_d;
   logic                       flush_pend_q,   flush_pend_d;
   logic                       pred_valid_q,   pred_valid_d;
   logic [31:0]                stat_total_q,   stat_total_d;
   logic [31:0]                stat_correct_q, stat_correct_d;

   logic [TABLE_ADR_WIDTH-1:0] lkp_idx;
   logic [TABLE_ADR_WIDTH-1:0] upd_idx;
   logic                       in_idle;
   logic                       flush_hold;
   logic                       upd_rdy;
   logic                       lkp_rdy;
   logic                       upd_acc;
   logic                       lkp_acc;
   logic [CTR_WIDTH-1:0]       ctr_next;
   logic                       mem_en_c;
   logic                       mem_we_c;
   logic [TABLE_ADR_WIDTH-1:0] mem_addr_c;
   logic [CTR_WIDTH-1:0]       mem_wdata_c;
   logic                       unused_pc_bits;

   assign lkp_idx = bus.lkp_pc[TABLE_ADR_WIDTH+1:2];
   assign upd_idx = bus.upd_pc[TABLE_ADR_WIDTH+1:2];
   assign unused_pc_bits = ^{bus.lkp_pc[31:TABLE_ADR_WIDTH+2], bus.lkp_pc[1:0],
                             bus.upd_pc[31:TABLE_ADR_WIDTH+2], bus.upd_pc[1:0]};

   // A flush seen during an update is remembered so it wins the next IDLE
   // cycle even if the request was only a pulse.
   assign in_idle    = (state_q == ST_IDLE);
   assign flush_hold = bus.flush_req | flush_pend_q;
   assign upd_rdy    = in_idle & ~flush_hold;
   assign lkp_rdy    = in_idle & ~flush_hold & ~bus.upd_valid;
   assign upd_acc    = bus.upd_valid & upd_rdy;
   assign lkp_acc    = bus.lkp_valid & lkp_rdy;

   // Saturating counter step applied in the write half of an update.
   always_comb begin
      ctr_next = bus.mem_rdata;
      if (upd_taken_q && (bus.mem_rdata != CTR_MAX)) begin
         ctr_next = bus.mem_rdata + 1'b1;
      end else if (!upd_taken_q && (bus.mem_rdata != CTR_MIN)) begin
         ctr_next = bus.mem_rdata - 1'b1;
      end
   end

   // Next-state logic for the FSM, latched update fields and statistics.
   always_comb begin
      state_d        = state_q;
      flush_idx_d    = flush_idx_q;
      upd_idx_d      = upd_idx_q;
      upd_taken_d    = upd_taken_q;
      flush_pend_d   = flush_pend_q;
      pred_valid_d   = lkp_acc;
      stat_total_d   = stat_total_q;
      stat_correct_d = stat_correct_q;
      case (state_q)
         ST_FLUSH: begin
            flush_idx_d = flush_idx_q + 1'b1;
            if (flush_idx_q == LAST_IDX) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (flush_hold) begin
               state_d        = ST_FLUSH;
               flush_idx_d    = '0;
               flush_pend_d   = 1'b0;
               stat_total_d   = '0;
               stat_correct_d = '0;
            end else if (upd_acc) begin
               state_d      = ST_UPD_RD;
               upd_idx_d    = upd_idx;
               upd_taken_d  = bus.upd_taken;
               stat_total_d = stat_total_q + 32'd1;
               if (bus.upd_pred == bus.upd_taken) begin
                  stat_correct_d = stat_correct_q + 32'd1;
               end
            end
         end
         ST_UPD_RD: begin
            state_d = ST_UPD_WR;
            if (bus.flush_req) flush_pend_d = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            if (bus.flush_req) flush_pend_d = 1'b1;
         end
      endcase
   end

   // RAM port mux: exactly one access source per state.
   always_comb begin
      mem_en_c    = 1'b0;
      mem_we_c    = 1'b0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
      case (state_q)
         ST_FLUSH: begin
            mem_en_c   = 1'b1;
            mem_we_c   = 1'b1;
            mem_addr_c = flush_idx_q;
         end
         ST_IDLE: begin
            if (lkp_acc) begin
               mem_en_c   = 1'b1;
               mem_addr_c = lkp_idx;
            end
         end
         ST_UPD_RD: begin
            mem_en_c   = 1'b1;
            mem_addr_c = upd_idx_q;
         end
         default: begin
            mem_en_c    = 1'b1;
            mem_we_c    = 1'b1;
            mem_addr_c  = upd_idx_q;
            mem_wdata_c = ctr_next;
         end
      endcase
   end

   // State registers; reset abandons any operation and restarts the sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_FLUSH;
         flush_idx_q    <= '0;
         upd_idx_q      <= '0;
         upd_taken_q    <= 1'b0;
         flush_pend_q   <= 1'b0;
         pred_valid_q   <= 1'b0;
         stat_total_q   <= '0;
         stat_correct_q <= '0;
      end else begin
         state_q        <= state_d;
         flush_idx_q    <= flush_idx_d;
         upd_idx_q      <= upd_idx_d;
         upd_taken_q    <= upd_taken_d;
         flush_pend_q   <= flush_pend_d;
         pred_valid_q   <= pred_valid_d;
         stat_total_q   <= stat_total_d;
         stat_correct_q <= stat_correct_d;
      end
   end

   // The RAM is kept idle for as long as reset is held.
   assign bus.mem_en       = mem_en_c & rst_n;
   assign bus.mem_we       = mem_we_c & rst_n;
   assign bus.mem_addr     = mem_addr_c;
   assign bus.mem_wdata    = mem_wdata_c;
   assign bus.flush_busy   = (state_q == ST_FLUSH);
   assign bus.upd_ready    = upd_rdy;
   assign bus.lkp_ready    = lkp_rdy;
   assign bus.pred_valid   = pred_valid_q;
   assign bus.pred_taken   = pred_valid_q & bus.mem_rdata[CTR_WIDTH-1];
   assign bus.stat_total   = stat_total_q;
   assign bus.stat_correct = stat_correct_q;
   assign dbg_state_o      = state_q;

endmodule
